// File: rtl/io_fabric_pkg.sv
// Shared definitions for the memory-mapped I/O fabric: region encoding,
// timer register offsets and timer control bit positions.
package io_fabric_pkg;

  typedef enum logic [1:0] {
    REG_RAM = 2'b00,
    REG_OUT = 2'b01,
    REG_IN  = 2'b10,
    REG_TMR = 2'b11
  } region_t;

  localparam logic [1:0] TMR_LOAD  = 2'd0;
  localparam logic [1:0] TMR_COUNT = 2'd1;
  localparam logic [1:0] TMR_CTRL  = 2'd2;

  localparam int CTRL_EXP = 0;
  localparam int CTRL_EN  = 1;

endpackage

// File: rtl/io_timer.sv
// Interval timer: reloads COUNT from LOAD on reaching zero and sets a sticky
// EXP flag; expiry beats a same-cycle clear, a LOAD write beats the reload.
module io_timer
  import io_fabric_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_we,
  input  logic              ctrl_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] load,
  output logic              en,
  output logic              exp
);

  logic              expire;
  logic [DATA_W-1:0] count_next;
  logic              exp_next;
  logic              en_next;

  always_comb begin
    expire     = en && (count == '0);
    count_next = count;
    if (load_we) begin
      count_next = wdata;
    end else if (en) begin
      count_next = expire ? load : (count - DATA_W'(1));
    end

    exp_next = exp;
    if (expire) begin
      exp_next = 1'b1;
    end else if (ctrl_we && wdata[CTRL_EXP]) begin
      exp_next = 1'b0;
    end

    en_next = ctrl_we ? wdata[CTRL_EN] : en;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      load  <= '0;
      en    <= 1'b0;
      exp   <= 1'b0;
    end else begin
      count <= count_next;
      if (load_we) load <= wdata;
      en    <= en_next;
      exp   <= exp_next;
    end
  end

endmodule

// File: rtl/io_mem_fabric.sv
// Four-region memory-mapped fabric: RAM, output registers, synchronised
// inputs and an interval timer, all read back on DIN with one cycle latency.
module io_mem_fabric
  import io_fabric_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 9,
  parameter int RAM_AW = 7,
  parameter int N_OUT  = 1,
  parameter int N_IN   = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_W-1:0]       ADDR,
  input  logic [DATA_W-1:0]       DOUT,
  input  logic                    W,
  output logic [DATA_W-1:0]       DIN,
  output logic [N_OUT*DATA_W-1:0] LEDS,
  input  logic [N_IN*DATA_W-1:0]  SW,
  output logic                    IRQ
);

  region_t     region;
  logic [2:0]  idx;
  logic [1:0]  toff;
  logic        wr;

  assign region = region_t'(ADDR[ADDR_W-1 -: 2]);
  assign idx    = ADDR[2:0];
  assign toff   = ADDR[1:0];
  // A write presented during reset must not land anywhere, RAM included.
  assign wr     = W && !RST;

  // Single-port read-first RAM; contents deliberately not reset.
  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic [DATA_W-1:0] ram_q;

  always_ff @(posedge CLK) begin
    if (wr && region == REG_RAM) ram[ADDR[RAM_AW-1:0]] <= DOUT;
    ram_q <= ram[ADDR[RAM_AW-1:0]];
  end

  logic [DATA_W-1:0] out_reg [N_OUT];

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
      always_ff @(posedge CLK) begin
        if (RST) begin
          out_reg[gi] <= '0;
        end else if (wr && region == REG_OUT && idx == 3'(gi)) begin
          out_reg[gi] <= DOUT;
        end
      end
      assign LEDS[gi*DATA_W +: DATA_W] = out_reg[gi];
    end
  endgenerate

  logic [DATA_W-1:0] sync1_reg [N_IN];
  logic [DATA_W-1:0] sync2_reg [N_IN];

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
      always_ff @(posedge CLK) begin
        if (RST) begin
          sync1_reg[gi] <= '0;
          sync2_reg[gi] <= '0;
        end else begin
          sync1_reg[gi] <= SW[gi*DATA_W +: DATA_W];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  logic [DATA_W-1:0] tmr_count;
  logic [DATA_W-1:0] tmr_load;
  logic              tmr_en;
  logic              tmr_exp;

  io_timer #(.DATA_W(DATA_W)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .load_we (wr && region == REG_TMR && toff == TMR_LOAD),
    .ctrl_we (wr && region == REG_TMR && toff == TMR_CTRL),
    .wdata   (DOUT),
    .count   (tmr_count),
    .load    (tmr_load),
    .en      (tmr_en),
    .exp     (tmr_exp)
  );

  assign IRQ = tmr_exp;

  // Peripheral read data is captured with pre-edge values, matching RAM read-first.
  logic [DATA_W-1:0] periph_rd;

  always_comb begin
    periph_rd = '0;
    case (region)
      REG_OUT: begin
        for (int k = 0; k < N_OUT; k++) begin
          if (idx == 3'(k)) periph_rd = out_reg[k];
        end
      end
      REG_IN: begin
        for (int k = 0; k < N_IN; k++) begin
          if (idx == 3'(k)) periph_rd = sync2_reg[k];
        end
      end
      REG_TMR: begin
        case (toff)
          TMR_LOAD:  periph_rd = tmr_load;
          TMR_COUNT: periph_rd = tmr_count;
          TMR_CTRL: begin
            periph_rd[CTRL_EXP] = tmr_exp;
            periph_rd[CTRL_EN]  = tmr_en;
          end
          default:   periph_rd = '0;
        endcase
      end
      default: periph_rd = '0;
    endcase
  end

  region_t           region_q;
  logic [DATA_W-1:0] periph_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      region_q <= REG_IN;
      periph_q <= '0;
    end else begin
      region_q <= region;
      periph_q <= periph_rd;
    end
  end

  assign DIN = (region_q == REG_RAM) ? ram_q : periph_q;

endmodule

// File: tb/tb_io_mem_fabric.sv
// Bench for io_mem_fabric: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_io_mem_fabric;

  localparam int DW = 9;
  localparam int NO = 2;
  localparam int NI = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [8:0]    ADDR = '0;
  logic [DW-1:0] DOUT = '0;
  logic          W = 1'b0;
  logic [DW-1:0] DIN;
  logic [NO*DW-1:0] LEDS;
  logic [NI*DW-1:0] SW = '0;
  logic          IRQ;

  io_mem_fabric #(
    .DATA_W(DW), .ADDR_W(9), .RAM_AW(7), .N_OUT(NO), .N_IN(NI)
  ) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DOUT(DOUT), .W(W),
    .DIN(DIN), .LEDS(LEDS), .SW(SW), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model: state of every architectural register, updated per edge.
  logic [DW-1:0] m_ram [128];
  bit            m_known [128];
  logic [DW-1:0] m_leds [NO];
  logic [DW-1:0] m_s1 [NI];
  logic [DW-1:0] m_s2 [NI];
  logic [DW-1:0] m_load, m_count, m_din;
  bit            m_en, m_exp, m_din_known;
  logic [1:0]    t_reg;
  int            t_idx;
  int            t_a;
  bit            t_expire, t_lw, t_cw;

  initial begin
    for (int i = 0; i < 128; i++) m_known[i] = 1'b0;
  end

  always @(posedge CLK) begin
    if (RST) begin
      m_din = '0; m_din_known = 1'b1;
      for (int k = 0; k < NO; k++) m_leds[k] = '0;
      for (int k = 0; k < NI; k++) begin m_s1[k] = '0; m_s2[k] = '0; end
      m_load = '0; m_count = '0; m_en = 1'b0; m_exp = 1'b0;
    end else begin
      t_reg = ADDR[8:7];
      t_idx = int'(ADDR[2:0]);
      t_a   = int'(ADDR[6:0]);
      m_din = '0; m_din_known = 1'b1;
      case (t_reg)
        2'd0: begin m_din_known = m_known[t_a]; m_din = m_ram[t_a]; end
        2'd1: if (t_idx < NO) m_din = m_leds[t_idx];
        2'd2: if (t_idx < NI) m_din = m_s2[t_idx];
        default: case (ADDR[1:0])
          2'd0: m_din = m_load;
          2'd1: m_din = m_count;
          2'd2: m_din = {7'd0, m_en, m_exp};
          default: m_din = '0;
        endcase
      endcase
      for (int k = 0; k < NI; k++) begin
        m_s2[k] = m_s1[k];
        m_s1[k] = SW[k*DW +: DW];
      end
      if (W && t_reg == 2'd0) begin m_ram[t_a] = DOUT; m_known[t_a] = 1'b1; end
      if (W && t_reg == 2'd1 && t_idx < NO) m_leds[t_idx] = DOUT;
      t_lw = W && t_reg == 2'd3 && ADDR[1:0] == 2'd0;
      t_cw = W && t_reg == 2'd3 && ADDR[1:0] == 2'd2;
      t_expire = m_en && (m_count == 0);
      if (t_lw) m_count = DOUT;
      else if (m_en) m_count = t_expire ? m_load : m_count - 9'd1;
      if (t_lw) m_load = DOUT;
      if (t_expire) m_exp = 1'b1;
      else if (t_cw && DOUT[0]) m_exp = 1'b0;
      if (t_cw) m_en = DOUT[1];
    end
    #1;
    if (m_din_known) check("model_din", 32'(DIN), 32'(m_din));
    check("model_leds", 32'(LEDS), 32'({m_leds[1], m_leds[0]}));
    check("model_irq", 32'(IRQ), 32'(m_exp));
  end

  task automatic drive(input logic r, input logic w, input logic [8:0] a, input logic [8:0] d);
    @(negedge CLK);
    RST = r; W = w; ADDR = a; DOUT = d;
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic step(input logic r, input logic w, input logic [8:0] a, input logic [8:0] d);
    drive(r, w, a, d);
    settle();
  endtask

  logic       rr, rw;
  logic [8:0] ra, rd;

  initial begin
    step(1'b1, 1'b0, 9'h000, 9'h000);
    step(1'b1, 1'b0, 9'h000, 9'h000);
    check("rst_din", 32'(DIN), 32'h0);
    check("rst_leds", 32'(LEDS), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);

    // RAM write, read-back and read-first behaviour
    step(1'b0, 1'b1, 9'h005, 9'h1A5);
    step(1'b0, 1'b0, 9'h005, 9'h000);
    check("ram_read", 32'(DIN), 32'h1A5);
    step(1'b0, 1'b1, 9'h005, 9'h0F0);
    check("ram_read_first", 32'(DIN), 32'h1A5);
    step(1'b0, 1'b0, 9'h005, 9'h000);
    check("ram_new", 32'(DIN), 32'h0F0);

    // Output registers and out-of-range index
    step(1'b0, 1'b1, 9'h080, 9'h155);
    check("leds_wr", 32'(LEDS), 32'h00155);
    step(1'b0, 1'b0, 9'h081, 9'h000);
    check("out1_rd", 32'(DIN), 32'h0);
    step(1'b0, 1'b1, 9'h087, 9'h1FF);
    check("out7_wr_ignored", 32'(LEDS), 32'h00155);
    step(1'b0, 1'b0, 9'h087, 9'h000);
    check("out7_rd", 32'(DIN), 32'h0);
    step(1'b0, 1'b0, 9'h080, 9'h000);
    check("out0_rd", 32'(DIN), 32'h155);

    // Input synchroniser latency
    drive(1'b0, 1'b0, 9'h100, 9'h000);
    SW = 18'h000AA;
    settle();
    check("sw_edge1", 32'(DIN), 32'h0);
    settle();
    check("sw_edge2", 32'(DIN), 32'h0);
    settle();
    check("sw_edge3", 32'(DIN), 32'h0AA);

    // Timer period LOAD+1, sticky flag and clear
    step(1'b0, 1'b1, 9'h180, 9'h003);
    step(1'b0, 1'b1, 9'h182, 9'h002);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    check("tmr_c1", 32'(IRQ), 32'h0);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    check("tmr_c2", 32'(IRQ), 32'h0);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    check("tmr_c3", 32'(IRQ), 32'h0);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    check("tmr_expire", 32'(IRQ), 32'h1);
    step(1'b0, 1'b1, 9'h182, 9'h003);
    check("tmr_clear", 32'(IRQ), 32'h0);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    check("tmr_c6", 32'(IRQ), 32'h0);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    check("tmr_c7", 32'(IRQ), 32'h0);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    check("tmr_expire2", 32'(IRQ), 32'h1);
    step(1'b0, 1'b0, 9'h181, 9'h000);
    check("tmr_count_rd", 32'(DIN), 32'h3);

    // Expiry wins over a same-cycle clear
    step(1'b0, 1'b1, 9'h180, 9'h000);
    step(1'b0, 1'b1, 9'h182, 9'h003);
    check("set_wins", 32'(IRQ), 32'h1);
    step(1'b0, 1'b1, 9'h182, 9'h001);
    check("set_wins_en_off", 32'(IRQ), 32'h1);
    step(1'b0, 1'b1, 9'h182, 9'h001);
    check("clear_idle", 32'(IRQ), 32'h0);

    // Reset mid-count with a RAM write pending
    step(1'b0, 1'b1, 9'h180, 9'h050);
    step(1'b0, 1'b1, 9'h182, 9'h002);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    step(1'b1, 1'b1, 9'h005, 9'h123);
    check("mid_rst_din", 32'(DIN), 32'h0);
    check("mid_rst_leds", 32'(LEDS), 32'h0);
    check("mid_rst_irq", 32'(IRQ), 32'h0);
    step(1'b0, 1'b0, 9'h005, 9'h000);
    check("rst_ram_kept", 32'(DIN), 32'h0F0);
    step(1'b0, 1'b0, 9'h181, 9'h000);
    check("rst_count", 32'(DIN), 32'h0);
    step(1'b0, 1'b0, 9'h182, 9'h000);
    check("rst_ctrl", 32'(DIN), 32'h0);
    step(1'b0, 1'b0, 9'h180, 9'h000);
    check("rst_load", 32'(DIN), 32'h0);

    // Randomized traffic; the model process checks every cycle
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      rw = 1'($urandom_range(0, 1));
      ra = 9'($urandom);
      rd = 9'($urandom);
      if (ra[8:7] == 2'd3 && ra[1:0] == 2'd0) rd = 9'($urandom_range(0, 6));
      if (ra[8:7] == 2'd3 && ra[1:0] == 2'd2) rd = 9'($urandom_range(0, 3));
      drive(rr, rw, ra, rd);
      if ($urandom_range(0, 15) == 0) SW = 18'($urandom);
      settle();
    end

    step(1'b0, 1'b0, 9'h000, 9'h000);
    step(1'b0, 1'b0, 9'h000, 9'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
